// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and defaults for the shared_reg_arbiter slice.
// Optional burst-lock feature is enabled with SHARED_REG_LOCK_EN.
package shared_reg_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int unsigned DEF_N         = 4;
    localparam int unsigned DEF_W         = 4;
    localparam int unsigned DEF_MAX_BURST = 4;

    // Index width that stays at least one bit wide for tiny counts.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEF_IDX_W = idx_w(DEF_N);

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// Requester-side bus of the shared register arbiter: requests/data in, grant and stored state out.
// Lock wires are present in every build; SHARED_REG_LOCK_EN decides whether the arbiter reads them.
interface shared_reg_arbiter_if
    import shared_reg_pkg::*;
#(
    parameter int unsigned N = DEF_N,
    parameter int unsigned W = DEF_W
);

    logic [N-1:0]        req;
    logic [N-1:0]        lock;
    logic [N*W-1:0]      wdata;
    logic [N-1:0]        gnt;
    logic [W-1:0]        q;
    logic [idx_w(N)-1:0] owner;
    logic                q_valid;
    logic                busy;

    modport master (
        output req, lock, wdata,
        input  gnt, q, owner, q_valid, busy
    );

    modport slave (
        input  req, lock, wdata,
        output gnt, q, owner, q_valid, busy
    );

endinterface

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from ptr+1, modulo N.
// Used by shared_reg_arbiter (SHARED_REG_LOCK_EN does not affect this block).
module rr_pick
    import shared_reg_pkg::*;
#(
    parameter int unsigned N  = DEF_N,
    parameter int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          valid
);

    int unsigned cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        cand   = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = (32'(ptr) + k) % N;
            if (!valid && req[cand[IW-1:0]]) begin
                valid                = 1'b1;
                idx                  = cand[IW-1:0];
                onehot[cand[IW-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter for one shared W-bit register; one grant at a time, one-hot grant = write ack.
// Define SHARED_REG_LOCK_EN to let a locked owner keep GRANT for up to MAX_BURST consecutive writes.
module shared_reg_arbiter
    import shared_reg_pkg::*;
#(
    parameter int unsigned N         = DEF_N,
    parameter int unsigned W         = DEF_W,
    parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
    input  logic                 clk,
    input  logic                 reset,
    shared_reg_arbiter_if.slave  bus
);

    localparam int unsigned IW = idx_w(N);

    state_t          state, state_nxt;
    logic [N-1:0]    gnt_r, gnt_nxt;
    logic [IW-1:0]   winner, winner_nxt;
    logic [IW-1:0]   ptr, ptr_nxt;
    logic [IW-1:0]   owner_r, owner_nxt;
    logic [W-1:0]    q_r, q_nxt;
    logic            q_valid_r, q_valid_nxt;

    logic [N-1:0]    pick_onehot;
    logic [IW-1:0]   pick_idx;
    logic            pick_valid;
    logic            win_req;
    logic [W-1:0]    win_data;
    logic            cont;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req    (bus.req),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    assign win_req  = bus.req[winner];
    assign win_data = bus.wdata[32'(winner) * W +: W];

`ifdef SHARED_REG_LOCK_EN
    localparam int unsigned BW = idx_w(MAX_BURST);
    logic [BW-1:0] burst, burst_nxt;

    // A continued cycle keeps the same winner and commits another write next edge.
    assign cont = (state == GRANT) && bus.lock[winner] && win_req
                  && (32'(burst) + 1 < MAX_BURST);

    always_comb begin
        burst_nxt = '0;
        if (cont) begin
            burst_nxt = burst + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            burst <= '0;
        end else begin
            burst <= burst_nxt;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^{bus.lock, 32'(MAX_BURST)};
    assign cont        = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        gnt_nxt     = gnt_r;
        winner_nxt  = winner;
        ptr_nxt     = ptr;
        q_nxt       = q_r;
        owner_nxt   = owner_r;
        q_valid_nxt = q_valid_r;
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nxt  = GRANT;
                    gnt_nxt    = pick_onehot;
                    winner_nxt = pick_idx;
                end
            end
            GRANT: begin
                // Pointer advances even on a cancelled write so the dropper loses its turn.
                ptr_nxt = winner;
                if (win_req) begin
                    q_nxt       = win_data;
                    owner_nxt   = winner;
                    q_valid_nxt = 1'b1;
                end
                if (!cont) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            gnt_r     <= '0;
            winner    <= '0;
            ptr       <= IW'(N - 1);
            owner_r   <= '0;
            q_r       <= '0;
            q_valid_r <= 1'b0;
        end else begin
            state     <= state_nxt;
            gnt_r     <= gnt_nxt;
            winner    <= winner_nxt;
            ptr       <= ptr_nxt;
            owner_r   <= owner_nxt;
            q_r       <= q_nxt;
            q_valid_r <= q_valid_nxt;
        end
    end

    assign bus.gnt     = gnt_r;
    assign bus.q       = q_r;
    assign bus.owner   = owner_r;
    assign bus.q_valid = q_valid_r;
    assign bus.busy    = (state == GRANT);

endmodule
